// File: rtl/eu_issue.sv
// Three-state issue unit: reads operands from a small register file, drives an
// external combinational ALU, and writes the result back. Optional EU_ISSUE_FLAGS_EN adds Z/N status flags.
module eu_issue #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    localparam int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
`ifdef EU_ISSUE_FLAGS_EN
    output logic              flag_z,
    output logic              flag_n,
`endif
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [AW-1:0]     in_dst,
    input  logic [AW-1:0]     in_srca,
    input  logic [AW-1:0]     in_srcb,
    input  logic [DATA_W-1:0] in_imm,
    output logic [3:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_operandA,
    output logic [DATA_W-1:0] alu_operandB,
    input  logic [DATA_W-1:0] alu_result,
    output logic              wb_valid,
    output logic [AW-1:0]     wb_dst,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy,
    input  logic [AW-1:0]     dbg_rd_addr,
    output logic [DATA_W-1:0] dbg_rd_data
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'hE;
    localparam logic [3:0] OP_ILL = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                accept;
    logic                commit;
    logic [AW-1:0]       dst;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   result;
    logic [DATA_W-1:0]   regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOP and illegal opcodes walk through EXEC/WB but never commit.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = WB;
            WB: begin
                state_nxt = IDLE;
                commit    = (alu_opcode != OP_NOP) && (alu_opcode != OP_ILL);
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign dbg_rd_data = regs[dbg_rd_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_opcode   <= '0;
            alu_operandA <= '0;
            alu_operandB <= '0;
            dst          <= '0;
            imm          <= '0;
            result       <= '0;
            wb_valid     <= 1'b0;
            wb_dst       <= '0;
            wb_data      <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wb_valid <= commit;
            if (accept) begin
                alu_opcode   <= in_opcode;
                alu_operandA <= regs[in_srca];
                alu_operandB <= regs[in_srcb];
                dst          <= in_dst;
                imm          <= in_imm;
            end
            if (state == EXEC) begin
                result <= (alu_opcode == OP_LDI) ? imm : alu_result;
            end
            // Writing at the end of WB lets an accept on the following edge see the new value.
            if (commit) begin
                regs[dst] <= result;
                wb_dst    <= dst;
                wb_data   <= result;
            end
        end
    end

`ifdef EU_ISSUE_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (wb_valid) begin
            flag_z <= (wb_data == '0);
            flag_n <= wb_data[DATA_W-1];
        end
    end
`endif

endmodule
